// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared types, segment encodings and the hex-to-segment helper
//             for the seven-segment scan driver.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Segment vector ordered {g,f,e,d,c,b,a}; 1 = lit (active-high view)
    typedef logic [6:0] seg7_t;

    // All segments dark in the active-high view
    localparam seg7_t SEG_BLANK = 7'h00;

    // Hex digit to segment pattern: 0-9 figures, then A b C d E F
    localparam seg7_t C_SEG7_HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
        return C_SEG7_HEX_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_decode
//  Purpose  : Combinational nibble to seven-segment decoder (active-high).
//  Revision : 1.0  initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg7_t      o_seg
);

    assign o_seg = hex_to_seg7(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed N-digit common-anode seven-segment driver with
//             a frame-aligned shadow copy of the displayed data and a blanking
//             gap at the start of every digit slot.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int C_CNT_W = $clog2(REFRESH_DIV);
    localparam int C_IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [C_CNT_W-1:0]  C_CNT_LAST = C_CNT_W'(REFRESH_DIV - 1);
    localparam logic [C_IDX_W-1:0]  C_IDX_LAST = C_IDX_W'(N_DIGITS - 1);
    localparam seg7_t               C_SEG_OFF  = SEG_ACT_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic                C_DP_OFF   = SEG_ACT_LOW;
    localparam logic [N_DIGITS-1:0] C_AN_OFF   = {N_DIGITS{AN_ACT_LOW}};

    // Scan position
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_IDX_W-1:0] r_idx;
    logic               r_wrap;
    logic               r_frame_done;

    // Displayed (shadow) data and the captured data waiting for a boundary
    logic [N_DIGITS-1:0][3:0] r_shadow;
    logic [N_DIGITS-1:0]      r_shadow_dp;
    logic [N_DIGITS-1:0][3:0] r_pend_val;
    logic [N_DIGITS-1:0]      r_pend_dp;
    logic                     r_pending;

    // Pin registers
    seg7_t               r_seg;
    logic                r_dp;
    logic [N_DIGITS-1:0] r_an;

    logic                w_slot_end;
    logic                w_boundary;
    logic                w_past_blank;
    logic                w_lit;
    seg7_t               w_seg_hi;
    logic [N_DIGITS-1:0] w_an_onehot;

    assign w_slot_end = (r_cnt == C_CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == C_IDX_LAST);

    // With no blanking gap every cycle of the slot may drive the anode
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign w_past_blank = 1'b1;
    end else begin : g_blank
        assign w_past_blank = (r_cnt >= C_CNT_W'(BLANK_CYCLES));
    end

    assign w_lit       = w_past_blank && digit_en[r_idx];
    assign w_an_onehot = N_DIGITS'(1) << r_idx;

    seg7_hex_decode u_decode (
        .i_nibble (r_shadow[r_idx]),
        .o_seg    (w_seg_hi)
    );

    // Slot counter, digit index and the delayed end-of-frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_wrap       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_wrap       <= w_boundary;
            r_frame_done <= r_wrap;
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + C_IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
        end
    end

    // Capture on load; promote to the shadow only at a frame boundary so a
    // frame never shows a mix of old and new digits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_pend_val  <= '0;
            r_pend_dp   <= '0;
            r_pending   <= 1'b0;
        end else if (w_boundary) begin
            r_pending <= 1'b0;
            if (load) begin
                r_shadow    <= value;
                r_shadow_dp <= dp;
            end else if (r_pending) begin
                r_shadow    <= r_pend_val;
                r_shadow_dp <= r_pend_dp;
            end
        end else if (load) begin
            r_pend_val <= value;
            r_pend_dp  <= dp;
            r_pending  <= 1'b1;
        end
    end

    // Pin registers: one anode at most, segments dark whenever no anode is on
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= C_SEG_OFF;
            r_dp  <= C_DP_OFF;
            r_an  <= C_AN_OFF;
        end else if (w_lit) begin
            r_seg <= w_seg_hi ^ {7{SEG_ACT_LOW}};
            r_dp  <= r_shadow_dp[r_idx] ^ SEG_ACT_LOW;
            r_an  <= w_an_onehot ^ {N_DIGITS{AN_ACT_LOW}};
        end else begin
            r_seg <= C_SEG_OFF;
            r_dp  <= C_DP_OFF;
            r_an  <= C_AN_OFF;
        end
    end

    assign seg        = r_seg;
    assign dp_out     = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule
`default_nettype wire
